// File: rtl/clock_meas_pkg.sv
// ---------------------------------------------------------------------------
// clock_meas_pkg
//   Shared types and helpers for the clock measurement block.
//   - state_t  : measurement FSM states (IDLE, GATE, HOLD)
//   - gate_len : gate window length in system cycles for a given exponent
// ---------------------------------------------------------------------------
package clock_meas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for start_i
    GATE = 2'd1,  // counting edges inside the gate window
    HOLD = 2'd2   // result presented, waiting for ready_i
  } state_t;

  // Gate window length, 2^gate_exp system cycles.
  function automatic int unsigned gate_len(input int unsigned gate_exp);
    return 32'd1 << gate_exp;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
//   Brings an asynchronous level into the clock_in_i domain through a
//   SYNC_STAGES-deep flop chain, then detects its rising edge against one
//   history flop. Rising edge on async_i appears on rise_o SYNC_STAGES+1
//   clock_in_i edges later (counting the edge that consumes the pulse).
//
// Ports:
//   clock_in_i  in   system clock
//   reset_ni    in   asynchronous active-low reset (all flops cleared)
//   async_i     in   asynchronous input level
//   level_o     out  synchronised level
//   rise_o      out  single-cycle pulse on a synchronised rising edge
// ---------------------------------------------------------------------------
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_in_i,
  input  logic reset_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // The history flop runs unconditionally so that a level already high out
  // of reset is absorbed before anything downstream can count it.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbour; blocking here would
  // collapse the synchroniser chain into a single stage.
  always_ff @(posedge clock_in_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~hist_q;

endmodule

// File: rtl/clock_meas.sv
// ---------------------------------------------------------------------------
// clock_meas
//   Counts rising edges of a slow, asynchronous clock (meas_clk_i) over a
//   gate window of 2^GATE_EXP enabled clock_in_i cycles and presents the
//   saturating count on a valid/ready handshake.
//
// Ports:
//   clock_in_i  in   system clock
//   reset_ni    in   asynchronous active-low reset
//   clear_i     in   synchronous clear, aborts and returns to IDLE
//   en_i        in   enable; low pauses the gate timer and edge counting
//   meas_clk_i  in   clock under measurement (asynchronous)
//   start_i     in   start one measurement (honoured in IDLE with en_i)
//   cont_i      in   re-arm into a new gate on each handshake
//   count_o     out  measured rising-edge count (saturating)
//   overflow_o  out  count saturated during the measurement
//   valid_o     out  count_o / overflow_o valid
//   ready_i     in   consumer accepts the result
//   busy_o      out  high while in GATE (including paused cycles)
// ---------------------------------------------------------------------------
module clock_meas
  import clock_meas_pkg::*;
#(
  parameter int GATE_EXP    = 8,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock_in_i,
  input  logic             reset_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             meas_clk_i,
  input  logic             start_i,
  input  logic             cont_i,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o
);

  localparam int unsigned       GATE_LEN  = gate_len(GATE_EXP);
  localparam logic [GATE_EXP:0] GATE_LAST = (GATE_EXP+1)'(GATE_LEN - 1);
  localparam logic [GATE_EXP:0] GATE_ONE  = (GATE_EXP+1)'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  // -------------------------------------------------------------------------
  // Synchroniser and rising-edge detect
  // -------------------------------------------------------------------------
  logic edge_p;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .clock_in_i (clock_in_i),
    .reset_ni   (reset_ni),
    .async_i    (meas_clk_i),
    .level_o    (),
    .rise_o     (edge_p)
  );

  // -------------------------------------------------------------------------
  // State and counters
  // -------------------------------------------------------------------------
  state_t            state_q,    state_d;
  logic [GATE_EXP:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic              edge_ovf_q, edge_ovf_d;
  logic [CNT_W-1:0]  count_q,    count_d;
  logic              overflow_q, overflow_d;

  // Edge count and overflow as they stand after including this cycle's edge.
  logic [CNT_W-1:0]  edge_cnt_inc;
  logic              edge_ovf_inc;

  always_ff @(posedge clock_in_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      edge_ovf_q <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      edge_ovf_q <= edge_ovf_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case/if tree leaves one unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    edge_ovf_d   = edge_ovf_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    edge_cnt_inc = edge_cnt_q;
    edge_ovf_inc = edge_ovf_q;

    // Saturate instead of wrapping; an edge at full scale only flags overflow.
    if (edge_p) begin
      if (&edge_cnt_q) begin
        edge_ovf_inc = 1'b1;
      end else begin
        edge_cnt_inc = edge_cnt_q + CNT_ONE;
      end
    end

    if (clear_i) begin
      // Clear beats everything, including a same-cycle handshake.
      state_d    = IDLE;
      gate_cnt_d = '0;
      edge_cnt_d = '0;
      edge_ovf_d = 1'b0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en_i && start_i) begin
            state_d    = GATE;
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            edge_ovf_d = 1'b0;
          end
        end

        GATE: begin
          // Paused cycles (en_i low) freeze both the window and the count.
          if (en_i) begin
            edge_cnt_d = edge_cnt_inc;
            edge_ovf_d = edge_ovf_inc;
            if (gate_cnt_q == GATE_LAST) begin
              // An edge in the final window cycle is part of the result.
              state_d    = HOLD;
              count_d    = edge_cnt_inc;
              overflow_d = edge_ovf_inc;
            end else begin
              gate_cnt_d = gate_cnt_q + GATE_ONE;
            end
          end
        end

        HOLD: begin
          if (ready_i) begin
            if (cont_i) begin
              state_d    = GATE;
              gate_cnt_d = '0;
              edge_cnt_d = '0;
              edge_ovf_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign valid_o    = (state_q == HOLD);
  assign busy_o     = (state_q == GATE);

endmodule

// File: tb/tb_clock_meas.sv
// ---------------------------------------------------------------------------
// tb_clock_meas
//   Two instances share all control inputs: dut (GATE_EXP=4, CNT_W=8) sees a
//   ref/4 measured clock, dut_sat (GATE_EXP=4, CNT_W=2) sees a ref/2 clock
//   and therefore saturates. Stimulus changes and output samples happen on
//   the falling edge of clock_in_i.
// ---------------------------------------------------------------------------
module tb_clock_meas;

  localparam int GATE_EXP = 4;
  localparam int CNT_W    = 8;
  localparam int SAT_W    = 2;

  logic             clock_in_i = 1'b0;
  logic             reset_ni;
  logic             clear_i;
  logic             en_i;
  logic             start_i;
  logic             cont_i;
  logic             ready_i;

  logic [CNT_W-1:0] count_o;
  logic             overflow_o, valid_o, busy_o;
  logic [SAT_W-1:0] sat_count_o;
  logic             sat_overflow_o, sat_valid_o, sat_busy_o;

  // Measured clocks: ref/4 and ref/2, offset 2 ns from the system edges.
  logic m4_free = 1'b0;
  logic m2_free = 1'b0;
  logic m_on;
  logic force_high;
  logic meas4, meas2;

  assign meas4 = force_high | (m_on & m4_free);
  assign meas2 = force_high | (m_on & m2_free);

  always #5 clock_in_i = ~clock_in_i;
  initial begin #2; forever #20 m4_free = ~m4_free; end
  initial begin #2; forever #10 m2_free = ~m2_free; end

  clock_meas #(.GATE_EXP(GATE_EXP), .CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clock_in_i (clock_in_i),
    .reset_ni   (reset_ni),
    .clear_i    (clear_i),
    .en_i       (en_i),
    .meas_clk_i (meas4),
    .start_i    (start_i),
    .cont_i     (cont_i),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .busy_o     (busy_o)
  );

  clock_meas #(.GATE_EXP(GATE_EXP), .CNT_W(SAT_W), .SYNC_STAGES(2)) dut_sat (
    .clock_in_i (clock_in_i),
    .reset_ni   (reset_ni),
    .clear_i    (clear_i),
    .en_i       (en_i),
    .meas_clk_i (meas2),
    .start_i    (start_i),
    .cont_i     (cont_i),
    .count_o    (sat_count_o),
    .overflow_o (sat_overflow_o),
    .valid_o    (sat_valid_o),
    .ready_i    (ready_i),
    .busy_o     (sat_busy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clock_in_i);
  endtask

  // Already in GATE at the current falling edge: count busy samples until
  // valid_o appears, optionally dropping en_i for pause_len cycles once
  // pause_at busy samples have been seen.
  task automatic wait_result(input int pause_at, input int pause_len,
                             output int busy_cnt, output bit got_valid);
    int pause_left;
    bit paused;
    busy_cnt   = 0;
    got_valid  = 1'b0;
    pause_left = 0;
    paused     = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (valid_o) begin
        got_valid = 1'b1;
        break;
      end
      if (busy_o) busy_cnt++;
      if (pause_left > 0) begin
        pause_left--;
        if (pause_left == 0) en_i = 1'b1;
      end else if (!paused && pause_len > 0 && busy_cnt == pause_at) begin
        en_i       = 1'b0;
        pause_left = pause_len;
        paused     = 1'b1;
      end
      @(negedge clock_in_i);
    end
    en_i = 1'b1;
  endtask

  task automatic run_meas(input int pause_at, input int pause_len,
                          output int busy_cnt, output bit got_valid);
    @(negedge clock_in_i);
    start_i = 1'b1;
    @(negedge clock_in_i);
    start_i = 1'b0;
    wait_result(pause_at, pause_len, busy_cnt, got_valid);
  endtask

  // Plain handshake back to IDLE (cont_i low).
  task automatic handshake(input string tag);
    ready_i = 1'b1;
    @(negedge clock_in_i);
    ready_i = 1'b0;
    check({tag, "_valid_after_hs"}, valid_o, 0);
    check({tag, "_busy_after_hs"},  busy_o,  0);
  endtask

  typedef struct {
    string name;
    int    pause_at;
    int    pause_len;
    bit    meas_on;
    int    exp_busy;
    int    exp_cnt;
    int    exp_ovf;
    int    exp_sat_cnt;
    int    exp_sat_ovf;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int busy_cnt;
    bit got_valid;

    // name, pause_at, pause_len, meas_on, busy, cnt, ovf, sat_cnt, sat_ovf
    vecs[0] = '{"plain",      0, 0, 1'b1, 16, 4, 0, 3, 1};
    vecs[1] = '{"pause8",     5, 8, 1'b1, 24, 4, 0, 3, 1};
    vecs[2] = '{"pause4",     1, 4, 1'b1, 20, 4, 0, 3, 1};
    vecs[3] = '{"stalled",    0, 0, 1'b0, 16, 0, 0, 0, 0};

    reset_ni   = 1'b0;
    clear_i    = 1'b0;
    en_i       = 1'b1;
    start_i    = 1'b0;
    cont_i     = 1'b0;
    ready_i    = 1'b0;
    m_on       = 1'b1;
    force_high = 1'b0;

    idle_cycles(3);
    check("rst_count",    count_o,        0);
    check("rst_overflow", overflow_o,     0);
    check("rst_valid",    valid_o,        0);
    check("rst_busy",     busy_o,         0);
    check("rst_sat_ovf",  sat_overflow_o, 0);
    reset_ni = 1'b1;
    idle_cycles(10);

    // ---- table-driven measurements ----
    for (int v = 0; v < 4; v++) begin
      m_on = vecs[v].meas_on;
      idle_cycles(10);
      run_meas(vecs[v].pause_at, vecs[v].pause_len, busy_cnt, got_valid);
      check({vecs[v].name, "_got_valid"}, got_valid,      1);
      check({vecs[v].name, "_busy_len"},  busy_cnt,       vecs[v].exp_busy);
      check({vecs[v].name, "_count"},     count_o,        vecs[v].exp_cnt);
      check({vecs[v].name, "_overflow"},  overflow_o,     vecs[v].exp_ovf);
      check({vecs[v].name, "_sat_valid"}, sat_valid_o,    1);
      check({vecs[v].name, "_sat_count"}, sat_count_o,    vecs[v].exp_sat_cnt);
      check({vecs[v].name, "_sat_ovf"},   sat_overflow_o, vecs[v].exp_sat_ovf);
      handshake(vecs[v].name);
    end
    m_on = 1'b1;
    idle_cycles(10);

    // ---- start_i with en_i low is ignored ----
    en_i    = 1'b0;
    start_i = 1'b1;
    @(negedge clock_in_i);
    start_i = 1'b0;
    en_i    = 1'b1;
    idle_cycles(3);
    check("start_no_en_busy", busy_o, 0);

    // ---- backpressure, then continuous re-arm ----
    run_meas(0, 0, busy_cnt, got_valid);
    check("bp_got_valid", got_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock_in_i);
      check("bp_valid_hold", valid_o, 1);
      check("bp_count_hold", count_o, 4);
    end
    ready_i = 1'b1;
    cont_i  = 1'b1;
    @(negedge clock_in_i);
    ready_i = 1'b0;
    cont_i  = 1'b0;
    check("cont_valid_drop", valid_o, 0);
    check("cont_busy_rise",  busy_o,  1);
    wait_result(0, 0, busy_cnt, got_valid);
    check("cont_got_valid", got_valid, 1);
    check("cont_busy_len",  busy_cnt,  16);
    check("cont_count",     count_o,   4);
    handshake("cont");

    // ---- clear mid-GATE ----
    idle_cycles(5);
    @(negedge clock_in_i);
    start_i = 1'b1;
    @(negedge clock_in_i);
    start_i = 1'b0;
    idle_cycles(5);
    clear_i = 1'b1;
    @(negedge clock_in_i);
    clear_i = 1'b0;
    check("clr_gate_busy",    busy_o,         0);
    check("clr_gate_valid",   valid_o,        0);
    check("clr_gate_count",   count_o,        0);
    check("clr_gate_sat_ovf", sat_overflow_o, 0);
    idle_cycles(30);
    check("clr_gate_discard", valid_o, 0);
    run_meas(0, 0, busy_cnt, got_valid);
    check("clr_fresh_valid", got_valid, 1);
    check("clr_fresh_count", count_o,   4);

    // ---- clear coincident with handshake ----
    check("clr_hs_pre_ovf", sat_overflow_o, 1);
    ready_i = 1'b1;
    clear_i = 1'b1;
    @(negedge clock_in_i);
    ready_i = 1'b0;
    clear_i = 1'b0;
    check("clr_hs_valid",   valid_o,        0);
    check("clr_hs_busy",    busy_o,         0);
    check("clr_hs_count",   count_o,        0);
    check("clr_hs_sat_ovf", sat_overflow_o, 0);
    idle_cycles(3);
    check("clr_hs_idle_busy", busy_o, 0);
    run_meas(0, 0, busy_cnt, got_valid);
    check("clr_hs_fresh_count", count_o, 4);
    handshake("clr_hs");

    // ---- measured clock held high through reset ----
    force_high = 1'b1;
    idle_cycles(5);
    reset_ni = 1'b0;
    idle_cycles(3);
    reset_ni = 1'b1;
    check("hi_rst_count", count_o, 0);
    idle_cycles(10);
    run_meas(0, 0, busy_cnt, got_valid);
    check("hi_got_valid", got_valid,      1);
    check("hi_busy_len",  busy_cnt,       16);
    check("hi_count",     count_o,        0);
    check("hi_sat_count", sat_count_o,    0);
    check("hi_sat_ovf",   sat_overflow_o, 0);
    handshake("hi");
    force_high = 1'b0;
    idle_cycles(10);

    // ---- asynchronous reset while holding a result ----
    run_meas(0, 0, busy_cnt, got_valid);
    check("rh_got_valid", got_valid, 1);
    check("rh_count_pre", count_o,   4);
    #2;
    reset_ni = 1'b0;
    #1;
    check("rh_valid_async", valid_o,     0);
    check("rh_count_async", count_o,     0);
    check("rh_sat_ovf",     sat_overflow_o, 0);
    @(negedge clock_in_i);
    reset_ni = 1'b1;
    idle_cycles(10);
    check("rh_wait_start", busy_o, 0);
    run_meas(0, 0, busy_cnt, got_valid);
    check("rh_after_valid", got_valid, 1);
    check("rh_after_count", count_o,   4);
    handshake("rh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
